// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the IO controller (port A)
// and the CNN engine (port B). Round-robin on ties, burst cap while the other
// side waits, IO interrupt preemption, and one IDLE cycle on every handover.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | nobody owns the RAM; arbitration decision made this cycle
// GNT_IO  | IO controller owns the RAM; a beat issues whenever io_req=1
// GNT_CNN | CNN engine owns the RAM; a beat issues whenever cnn_req=1
module ram_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_ack,
   output logic [DATA_W-1:0] io_rdata,
   input  logic              cnn_req,
   input  logic              cnn_we,
   input  logic [ADDR_W-1:0] cnn_addr,
   input  logic [DATA_W-1:0] cnn_wdata,
   output logic              cnn_gnt,
   output logic              cnn_ack,
   output logic [DATA_W-1:0] cnn_rdata,
   input  logic              io_prio,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, GNT_IO, GNT_CNN} state_t;

   state_t            state;
   logic              last_cnn;     // 1 = CNN was granted most recently
   logic [CNT_W-1:0]  count;
   logic              io_rd_q;
   logic              cnn_rd_q;
   logic [DATA_W-1:0] io_rdata_q;
   logic [DATA_W-1:0] cnn_rdata_q;
   logic              issue_io;
   logic              issue_cnn;
   logic              at_cap;

   assign io_gnt    = (state == GNT_IO);
   assign cnn_gnt   = (state == GNT_CNN);
   assign busy      = (state != IDLE);
   assign issue_io  = io_gnt & io_req;
   assign issue_cnn = cnn_gnt & cnn_req;
   assign at_cap    = (count == CNT_W'(MAX_BURST - 1));

   // RAM side: route the granted port's beat, drive zeros when nothing issues
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (issue_io) begin
         mem_en    = 1'b1;
         mem_we    = io_we;
         mem_addr  = io_addr;
         mem_wdata = io_wdata;
      end else if (issue_cnn) begin
         mem_en    = 1'b1;
         mem_we    = cnn_we;
         mem_addr  = cnn_addr;
         mem_wdata = cnn_wdata;
      end
   end

   // Read data passes straight through in the ack cycle, then holds
   assign io_rdata  = (io_ack & io_rd_q)   ? mem_rdata : io_rdata_q;
   assign cnn_rdata = (cnn_ack & cnn_rd_q) ? mem_rdata : cnn_rdata_q;

   // Arbitration FSM, burst counter, acks and read-data hold registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         last_cnn    <= 1'b1;
         count       <= '0;
         io_ack      <= 1'b0;
         cnn_ack     <= 1'b0;
         io_rd_q     <= 1'b0;
         cnn_rd_q    <= 1'b0;
         io_rdata_q  <= '0;
         cnn_rdata_q <= '0;
      end else begin
         io_ack   <= issue_io;
         cnn_ack  <= issue_cnn;
         io_rd_q  <= issue_io & ~io_we;
         cnn_rd_q <= issue_cnn & ~cnn_we;
         if (io_ack & io_rd_q)
            io_rdata_q <= mem_rdata;
         if (cnn_ack & cnn_rd_q)
            cnn_rdata_q <= mem_rdata;

         case (state)
            IDLE: begin
               if (io_req & (io_prio | ~cnn_req | last_cnn)) begin
                  state    <= GNT_IO;
                  last_cnn <= 1'b0;
                  count    <= '0;
               end else if (cnn_req) begin
                  state    <= GNT_CNN;
                  last_cnn <= 1'b1;
                  count    <= '0;
               end
            end
            GNT_IO: begin
               if (!io_req) begin
                  state <= IDLE;
               end else if (at_cap) begin
                  // cap with nobody waiting just restarts the burst window
                  count <= '0;
                  if (cnn_req)
                     state <= IDLE;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            GNT_CNN: begin
               if (!cnn_req) begin
                  state <= IDLE;
               end else begin
                  count <= at_cap ? '0 : count + CNT_W'(1);
                  // cap and interrupt together still produce a single release
                  if (io_req & (at_cap | io_prio))
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small registered-read RAM model.
module tb_ram_arbiter;

   logic        clk;
   logic        rst;
   logic        io_req, io_we, cnn_req, cnn_we, io_prio;
   logic [15:0] io_addr, io_wdata, cnn_addr, cnn_wdata;
   logic        io_gnt, io_ack, cnn_gnt, cnn_ack;
   logic [15:0] io_rdata, cnn_rdata;
   logic        mem_en, mem_we, busy;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata;
   logic [15:0] ram [0:255];

   int n_cmp = 0;
   int n_err = 0;

   ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(8)) dut (
      .clk(clk), .rst(rst),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_gnt(io_gnt), .io_ack(io_ack), .io_rdata(io_rdata),
      .cnn_req(cnn_req), .cnn_we(cnn_we), .cnn_addr(cnn_addr), .cnn_wdata(cnn_wdata),
      .cnn_gnt(cnn_gnt), .cnn_ack(cnn_ack), .cnn_rdata(cnn_rdata),
      .io_prio(io_prio),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: write on the edge, read data registered one cycle after mem_en
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we)
            ram[mem_addr[7:0]] <= mem_wdata;
         else
            mem_rdata <= ram[mem_addr[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      logic [2:0] exp3;
      int pos;
      for (int a = 0; a < 256; a++) ram[a] = 16'h0;
      mem_rdata = 16'h0;
      rst = 1'b0;
      io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
      cnn_req = 0; cnn_we = 0; cnn_addr = 0; cnn_wdata = 0; io_prio = 0;

      // reset state
      nxt(); nxt();
      smp();
      chk("rst_gnt_ack_busy", {io_gnt, cnn_gnt, io_ack, cnn_ack, busy}, 5'b0);
      chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 34'h0);
      chk("rst_rdata", {io_rdata, cnn_rdata}, 32'h0);
      nxt();
      rst = 1'b1;

      // IO-only write burst 0x10..0x12 <- 0xA1..0xA3
      io_req = 1; io_we = 1; io_addr = 16'h10; io_wdata = 16'hA1;
      smp();
      chk("wr_c0_gnt", {io_gnt, mem_en}, 2'b00);
      for (int i = 0; i < 3; i++) begin
         nxt();
         io_addr = 16'h10 + 16'(i); io_wdata = 16'hA1 + 16'(i);
         smp();
         chk("wr_gnt_en_we", {io_gnt, mem_en, mem_we}, 3'b111);
         chk("wr_addr_data", {mem_addr, mem_wdata}, {16'h10 + 16'(i), 16'hA1 + 16'(i)});
         chk("wr_ack", io_ack, (i > 0));
      end
      nxt();
      io_req = 0;
      smp();
      chk("wr_tail", {io_gnt, mem_en, io_ack}, 3'b101);
      nxt();
      smp();
      chk("wr_release", {io_gnt, io_ack, busy}, 3'b000);

      // tie from reset: IO first, one IDLE cycle, then CNN reads back
      nxt();
      rst = 1'b0;
      nxt();
      rst = 1'b1;
      io_req = 1; io_we = 0; io_addr = 16'h10;
      cnn_req = 1; cnn_we = 0; cnn_addr = 16'h10;
      smp();
      chk("tie_c0", {io_gnt, cnn_gnt}, 2'b00);
      nxt();
      smp();
      chk("tie_io_first", {io_gnt, cnn_gnt, mem_en}, 3'b101);
      nxt();
      io_req = 0;
      smp();
      chk("tie_io_rd", {io_ack, io_rdata}, {1'b1, 16'hA1});
      nxt();
      smp();
      chk("tie_idle", {io_gnt, cnn_gnt, busy}, 3'b000);
      for (int i = 0; i < 3; i++) begin
         nxt();
         cnn_addr = 16'h10 + 16'(i);
         smp();
         chk("tie_cnn_gnt", {cnn_gnt, mem_en, mem_addr}, {2'b11, 16'h10 + 16'(i)});
         if (i > 0) chk("tie_cnn_rd", {cnn_ack, cnn_rdata}, {1'b1, 16'hA0 + 16'(i)});
      end
      nxt();
      cnn_req = 0;
      smp();
      chk("tie_cnn_rd_last", {cnn_ack, cnn_rdata}, {1'b1, 16'hA3});
      nxt();
      smp();
      chk("tie_rdata_hold", {cnn_gnt, cnn_ack, cnn_rdata}, {2'b00, 16'hA3});

      // burst cap: both request continuously
      nxt();
      io_req = 1; io_we = 0; io_addr = 16'h20;
      cnn_req = 1; cnn_we = 0; cnn_addr = 16'h30;
      for (int k = 0; k < 28; k++) begin
         smp();
         if (k == 0) exp3 = 3'b000;
         else begin
            pos = (k - 1) % 9;
            if (pos == 8) exp3 = 3'b000;
            else if (((k - 1) / 9) % 2 == 0) exp3 = 3'b101;
            else exp3 = 3'b011;
         end
         chk($sformatf("cap_k%0d", k), {io_gnt, cnn_gnt, mem_en}, exp3);
         nxt();
      end
      io_req = 0; cnn_req = 0;
      smp();
      chk("cap_tail", {cnn_gnt, mem_en}, 2'b10);
      nxt(); nxt();

      // CNN alone for 20 beats, no gap at the cap
      cnn_req = 1; cnn_we = 1; cnn_addr = 16'h40; cnn_wdata = 16'hC0;
      nxt();
      for (int i = 0; i < 20; i++) begin
         cnn_addr = 16'h40 + 16'(i); cnn_wdata = 16'hC0 + 16'(i);
         smp();
         chk($sformatf("solo_b%0d", i), {cnn_gnt, mem_en, cnn_ack, mem_addr},
             {2'b11, (i > 0), 16'h40 + 16'(i)});
         nxt();
      end
      cnn_req = 0;
      smp();
      chk("solo_tail", {cnn_gnt, mem_en, cnn_ack}, 3'b101);
      nxt();
      smp();
      chk("solo_end", {cnn_gnt, cnn_ack}, 2'b00);

      // preemption of CNN at beat 3
      nxt();
      cnn_req = 1; cnn_we = 1; cnn_addr = 16'h60; cnn_wdata = 16'hD0;
      nxt(); nxt(); nxt();
      io_prio = 1; io_req = 1; io_we = 0; io_addr = 16'h10;
      smp();
      chk("pre_b3", {cnn_gnt, io_gnt, mem_en, mem_addr}, {3'b101, 16'h60});
      nxt();
      smp();
      chk("pre_idle", {cnn_gnt, io_gnt, busy, cnn_ack, mem_en}, 5'b00010);
      nxt();
      smp();
      chk("pre_io_gnt", {io_gnt, cnn_gnt, mem_en, mem_addr}, {3'b101, 16'h10});
      nxt();
      io_req = 0; io_prio = 0; cnn_req = 0;
      smp();
      chk("pre_io_rd", {io_ack, io_rdata}, {1'b1, 16'hA1});
      nxt(); nxt();

      // reset during IO beat 2
      io_req = 1; io_we = 1; io_addr = 16'h50; io_wdata = 16'hE0;
      nxt(); nxt();
      io_addr = 16'h51; io_wdata = 16'hE1;
      #1;
      chk("mid_b2", {io_gnt, mem_en, io_ack}, 3'b111);
      #1;
      rst = 1'b0;
      smp();
      chk("mid_rst_out", {io_gnt, cnn_gnt, io_ack, cnn_ack, busy, mem_en, mem_we}, 7'b0);
      chk("mid_rst_mem", {mem_addr, mem_wdata}, 32'h0);
      nxt();
      rst = 1'b1;
      smp();
      chk("mid_no_ack", {io_gnt, io_ack}, 2'b00);
      nxt();
      smp();
      chk("mid_regrant", {io_gnt, mem_en, io_ack}, 3'b110);
      nxt();
      io_req = 0;
      nxt(); nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
